// File: rtl/jk_seq_pkg.sv
// rtl/jk_seq_pkg.sv - shared constants and next-count helper for the JK modulo counter
//
// Purpose: direction encoding and the modulo next-count function used by
//          jk_mod_counter. Arithmetic is carried one bit wider than the count
//          so a modulus of 2**WIDTH does not overflow before the compare.
// Contents:
//   DIR_UP / DIR_DN  direction encoding for the up input
//   mod_next()       next count for a given current count, direction, modulus
package jk_seq_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Operands are 32/33 bits wide so any counter up to 32 bits can use it;
  // the caller casts the result back down to its own width.
  function automatic logic [31:0] mod_next(
    input logic [31:0] q,
    input logic        up,
    input logic [32:0] modulus
  );
    logic [32:0] w_sum;
    logic [32:0] w_top;
    if (up == DIR_UP) begin
      w_sum = {1'b0, q} + 33'd1;
      return (w_sum >= modulus) ? 32'd0 : w_sum[31:0];
    end else begin
      w_top = modulus - 33'd1;
      return (q == 32'd0) ? w_top[31:0] : (q - 32'd1);
    end
  endfunction

endpackage

// File: rtl/jk_bit.sv
// rtl/jk_bit.sv - single JK flip-flop, rising edge, async active-low reset
//
// Purpose: one state bit of the counter.
// Ports:
//   i_clk    rising-edge clock
//   i_rst_n  asynchronous active-low reset, clears o_q
//   i_j      J input
//   i_k      K input   (JK: 00 hold, 01 clear, 10 set, 11 toggle)
//   o_q      flop output
module jk_bit (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_j,
  input  logic i_k,
  output logic o_q
);

  logic r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= 1'b0;
    end else begin
      case ({i_j, i_k})
        2'b00:   r_q <= r_q;
        2'b01:   r_q <= 1'b0;
        2'b10:   r_q <= 1'b1;
        default: r_q <= ~r_q;
      endcase
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/jk_mod_counter.sv
// rtl/jk_mod_counter.sv - modulo-N up/down counter built from toggle-mode JK flops
//
// Purpose: counts 0..MODULUS-1 up or down with synchronous load, a combinational
//          terminal count and a registered wrap pulse. State lives in WIDTH
//          jk_bit instances driven with J=K=(q ^ next).
// Parameters:
//   WIDTH    counter width in bits
//   MODULUS  count range 0..MODULUS-1, 2 <= MODULUS <= 2**WIDTH
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous active-low reset (q=0, wrap=0)
//   en      count enable
//   up      direction, 1 = increment, 0 = decrement
//   load    synchronous load (priority over en)
//   d       load value, out-of-range values load 0
//   q       current count (flop outputs)
//   tc      terminal count, high during the cycle whose edge wraps
//   wrap    one-cycle pulse after a wrap edge
//   q_gray  registered Gray code of q (only with JK_CNT_GRAY_OUT_EN defined)
// Build option: JK_CNT_GRAY_OUT_EN adds the q_gray output.
module jk_mod_counter
  import jk_seq_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
`ifdef JK_CNT_GRAY_OUT_EN
  ,
  output logic [WIDTH-1:0] q_gray
`endif
);

  generate
    if ((MODULUS < 2) || (longint'(MODULUS) > (64'd1 << WIDTH))) begin : g_bad_modulus
      $error("jk_mod_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end
  endgenerate

  localparam logic [WIDTH:0]   L_MOD = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH-1:0] L_MAX = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_count;
  logic [WIDTH-1:0] w_load_val;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_t;
  logic             w_at_max;
  logic             w_at_zero;
  logic             r_wrap;

  assign w_count    = WIDTH'(mod_next(32'(w_q), up, 33'(MODULUS)));
  assign w_load_val = ({1'b0, d} < L_MOD) ? d : '0;

  always_comb begin
    w_next = w_q;
    if (load) begin
      w_next = w_load_val;
    end else if (en) begin
      w_next = w_count;
    end
  end

  // Only bits that change get J=K=1; the rest hold.
  assign w_t = w_q ^ w_next;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      jk_bit u_bit (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_j     (w_t[gi]),
        .i_k     (w_t[gi]),
        .o_q     (w_q[gi])
      );
    end
  endgenerate

  assign w_at_max  = (w_q == L_MAX);
  assign w_at_zero = (w_q == '0);
  assign tc = en & ~load & (((up == DIR_UP) & w_at_max) | ((up == DIR_DN) & w_at_zero));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= tc;
    end
  end

`ifdef JK_CNT_GRAY_OUT_EN
  logic [WIDTH-1:0] r_q_gray;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q_gray <= '0;
    end else begin
      r_q_gray <= w_next ^ (w_next >> 1);
    end
  end

  assign q_gray = r_q_gray;
`endif

  assign q    = w_q;
  assign wrap = r_wrap;

endmodule

// File: tb/tb_jk_mod_counter.sv
// tb/tb_jk_mod_counter.sv - self-checking bench for jk_mod_counter
module tb_jk_mod_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en_a = 1'b0, up_a = 1'b1, load_a = 1'b0;
  logic [3:0] d_a = '0;
  logic [3:0] q_a;
  logic       tc_a, wrap_a;
  logic       en_b = 1'b0, up_b = 1'b1, load_b = 1'b0;
  logic [2:0] d_b = '0;
  logic [2:0] q_b;
  logic       tc_b, wrap_b;
`ifdef JK_CNT_GRAY_OUT_EN
  logic [3:0] q_gray_a;
  logic [2:0] q_gray_b;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int q;
    bit wrap;
    bit tc;
    logic tc_obs;
    bit b;
  } sb_t;

  sb_t sb[$];
  int  m_q[2] = '{0, 0};

  always #5 clk = ~clk;

  jk_mod_counter #(.WIDTH(4), .MODULUS(10)) u_dut_a (
    .clk (clk), .rst (rst), .en (en_a), .up (up_a), .load (load_a), .d (d_a),
    .q (q_a), .tc (tc_a), .wrap (wrap_a)
`ifdef JK_CNT_GRAY_OUT_EN
    , .q_gray (q_gray_a)
`endif
  );

  jk_mod_counter #(.WIDTH(3), .MODULUS(8)) u_dut_b (
    .clk (clk), .rst (rst), .en (en_b), .up (up_b), .load (load_b), .d (d_b),
    .q (q_b), .tc (tc_b), .wrap (wrap_b)
`ifdef JK_CNT_GRAY_OUT_EN
    , .q_gray (q_gray_b)
`endif
  );

  function automatic int model_next(int q, bit en, bit up, bit load, int d, int m);
    if (load) return (d < m) ? d : 0;
    if (!en) return q;
    if (up) return (q == m - 1) ? 0 : q + 1;
    return (q == 0) ? m - 1 : q - 1;
  endfunction

  // Drives one edge on DUT a (b=0) or b (b=1), captures tc before the edge and
  // pushes the expected post-edge result; the other DUT is left idle.
  task automatic drive(input bit b, input bit en_i, input bit up_i, input bit load_i, input int d_i);
    sb_t e;
    int  m;
    m = b ? 8 : 10;
    @(negedge clk);
    if (b) begin
      en_b = en_i; up_b = up_i; load_b = load_i; d_b = 3'(d_i);
      en_a = 1'b0; load_a = 1'b0;
    end else begin
      en_a = en_i; up_a = up_i; load_a = load_i; d_a = 4'(d_i);
      en_b = 1'b0; load_b = 1'b0;
    end
    #1;
    e.b      = b;
    e.tc     = en_i && !load_i && ((up_i && m_q[b] == m - 1) || (!up_i && m_q[b] == 0));
    e.tc_obs = b ? tc_b : tc_a;
    e.wrap   = rst ? e.tc : 1'b0;
    m_q[b]   = rst ? model_next(m_q[b], en_i, up_i, load_i, d_i, m) : 0;
    e.q      = m_q[b];
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    sb_t e;
    n_checks++;
    if (q_a !== 4'd0 || wrap_a !== 1'b0 || q_b !== 3'd0) $display("FAIL reset_init: got q_a=%0d wrap_a=%b q_b=%0d want 0 0 0", q_a, wrap_a, q_b);
    else n_pass++;
`ifdef JK_CNT_GRAY_OUT_EN
    n_checks++;
    if (q_gray_b !== 3'b000) $display("FAIL reset_gray: got %b want 000", q_gray_b);
    else n_pass++;
`endif
    @(negedge clk);
    rst = 1'b1;
    drive(0, 1'b0, 1'b1, 1'b1, 7);
    e = sb.pop_front();
    n_checks++;
    if (q_a !== 4'(e.q) || q_a !== 4'd7) $display("FAIL reset_load7: got %0d want %0d", q_a, e.q);
    else n_pass++;
    #2;
    rst  = 1'b0;
    m_q  = '{0, 0};
    #1;
    n_checks++;
    if (q_a !== 4'd0 || wrap_a !== 1'b0) $display("FAIL reset_async: got q=%0d wrap=%b want q=0 wrap=0", q_a, wrap_a);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      drive(0, 1'b1, 1'b1, 1'b0, 0);
      e = sb.pop_front();
      n_checks++;
      if (q_a !== 4'd0 || wrap_a !== 1'b0) $display("FAIL reset_hold edge %0d: got q=%0d wrap=%b want q=0 wrap=0", i, q_a, wrap_a);
      else n_pass++;
    end
    @(negedge clk);
    en_a = 1'b0;
    rst  = 1'b1;
  endtask

  task automatic test_up_count();
    sb_t e;
    int  up_tab[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    for (int i = 0; i < 12; i++) begin
      drive(0, 1'b1, 1'b1, 1'b0, 0);
      e = sb.pop_front();
      n_checks++;
      if ({q_a, wrap_a, e.tc_obs} !== {4'(e.q), e.wrap, e.tc} || q_a !== 4'(up_tab[i]))
        $display("FAIL up_count step %0d: got q=%0d wrap=%b tc=%b want q=%0d wrap=%b tc=%b", i, q_a, wrap_a, e.tc_obs, up_tab[i], e.wrap, e.tc);
      else n_pass++;
    end
  endtask

  task automatic test_down_count();
    sb_t e;
    drive(0, 1'b0, 1'b1, 1'b1, 1);
    void'(sb.pop_front());
    for (int i = 0; i < 3; i++) begin
      drive(0, 1'b1, 1'b0, 1'b0, 0);
      e = sb.pop_front();
      n_checks++;
      if ({q_a, wrap_a, e.tc_obs} !== {4'(e.q), e.wrap, e.tc})
        $display("FAIL down_count step %0d: got q=%0d wrap=%b tc=%b want q=%0d wrap=%b tc=%b", i, q_a, wrap_a, e.tc_obs, e.q, e.wrap, e.tc);
      else n_pass++;
    end
  endtask

  task automatic test_load();
    sb_t e;
    int  ld_d[4]  = '{6, 12, 9, 4};
    int  ld_q[4]  = '{6, 0, 9, 4};
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b1, 1'b1, 1'b1, ld_d[i]);
      e = sb.pop_front();
      n_checks++;
      if ({q_a, wrap_a, e.tc_obs} !== {4'(ld_q[i]), 1'b0, 1'b0} || e.q != ld_q[i])
        $display("FAIL load d=%0d: got q=%0d wrap=%b tc=%b want q=%0d wrap=0 tc=0", ld_d[i], q_a, wrap_a, e.tc_obs, ld_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_hold_dir();
    sb_t e;
    drive(0, 1'b0, 1'b1, 1'b1, 5);
    void'(sb.pop_front());
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b0, i[0], 1'b0, 0);
      e = sb.pop_front();
      n_checks++;
      if ({q_a, wrap_a, e.tc_obs} !== {4'd5, 1'b0, 1'b0})
        $display("FAIL hold edge %0d: got q=%0d wrap=%b tc=%b want q=5 wrap=0 tc=0", i, q_a, wrap_a, e.tc_obs);
      else n_pass++;
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b1, ~i[0], 1'b0, 0);
      e = sb.pop_front();
      n_checks++;
      if ({q_a, wrap_a, e.tc_obs} !== {4'(e.q), e.wrap, e.tc} || q_a !== (i[0] ? 4'd5 : 4'd6))
        $display("FAIL direction step %0d: got q=%0d wrap=%b tc=%b want q=%0d", i, q_a, wrap_a, e.tc_obs, i[0] ? 5 : 6);
      else n_pass++;
    end
  endtask

  task automatic test_full_range();
    sb_t  e;
    logic [2:0] gray_tab[9] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000, 3'b001};
    int   n_wrap = 0;
    for (int i = 0; i < 9; i++) begin
      drive(1, 1'b1, 1'b1, 1'b0, 0);
      e = sb.pop_front();
      n_wrap += int'(wrap_b);
      n_checks++;
      if ({q_b, wrap_b, e.tc_obs} !== {3'(e.q), e.wrap, e.tc})
        $display("FAIL full_range step %0d: got q=%0d wrap=%b tc=%b want q=%0d wrap=%b tc=%b", i, q_b, wrap_b, e.tc_obs, e.q, e.wrap, e.tc);
      else n_pass++;
`ifdef JK_CNT_GRAY_OUT_EN
      n_checks++;
      if (q_gray_b !== gray_tab[i]) $display("FAIL gray step %0d: got %b want %b", i, q_gray_b, gray_tab[i]);
      else n_pass++;
`else
      if (gray_tab[i] === 3'bxxx) $display("unexpected gray table entry");
`endif
    end
    n_checks++;
    if (n_wrap != 1) $display("FAIL full_range_wrap_count: got %0d want 1", n_wrap);
    else n_pass++;
  endtask

  initial begin
    #1;
    test_reset();
    test_up_count();
    test_down_count();
    test_load();
    test_hold_dir();
    test_full_range();
    n_checks++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d entries want 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/jk_mod_counter.md
Name: jk_mod_counter

Overview:
- Parametrised modulo-N up/down counter.
- State is held in one JK flip-flop per bit, each driven in toggle mode (J=K=toggle).
- Next-state logic computes the target count; the toggle mask is state XOR next.
- Successor to the fixed 2-bit JK toggle FSM: generalised width/modulus, adds direction, synchronous load, terminal count and wrap flag.

Parameters:
- WIDTH, 4: counter width in bits.
- MODULUS, 10: count range 0..MODULUS-1.
- Legal range 2 <= MODULUS <= 2**WIDTH; an illegal value is an elaboration error via generate-time $error.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- rst  input  1  asynchronous, active-low reset; asserting rst=0 clears the state immediately.
- en  input  1  count enable.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous load request.
- d  input  WIDTH  load value.
- q  output  WIDTH  current count (registered; flop outputs directly).
- tc  output  1  terminal count, combinational.
- wrap  output  1  registered one-cycle pulse, high after a wrap edge.

Behaviour:
- Reset (rst=0, async): q=0, wrap=0, independent of clk. Counting resumes on the first rising edge after rst returns high.
- Priority per rising edge: load > en > hold.
- Load:
  - load=1: q <= d if d < MODULUS, else q <= 0.
  - Load never sets wrap; wrap <= 0.
  - load overrides en and up in the same cycle.
- Count, en=1 and load=0:
  - up=1: q <= q+1; q==MODULUS-1 wraps to 0.
  - up=0: q <= q-1; q==0 wraps to MODULUS-1.
- Hold, en=0 and load=0: q unchanged, wrap <= 0.
- tc = en & ~load & ((up & q==MODULUS-1) | (~up & q==0)). tc is therefore high during the cycle whose edge performs the wrap.
- wrap <= tc on each rising edge, so it is high exactly one cycle after the wrap edge. Back-to-back wraps (MODULUS=2, continuous en) keep wrap high on consecutive cycles.
- Direction change takes effect on the same edge with no pipeline delay.
- Latency: q reflects load/count one edge later; tc has zero latency.
- State encoding is plain binary.
- Toggle mask is t = q ^ next. Each bit i drives jk_bit with J=K=t[i].
- Arithmetic is done WIDTH+1 wide before the modulus compare, so MODULUS=2**WIDTH wraps correctly.
- Mid-operation reset: any pending load/count is discarded; q=0 and wrap=0 at once, with no glitch on the next edge.

Optional Feature:
- Macro JK_CNT_GRAY_OUT_EN adds output port q_gray [WIDTH-1:0].
  - q_gray is registered, q_gray = next ^ (next >> 1), updated on the same edge as q.
  - Reset value of q_gray is 0.
- Without the macro: port absent, no extra flops.
- q, tc and wrap behave identically in both builds.

Decomposition:
- Shared package jk_seq_pkg holds:
  - function mod_next(q, up, MODULUS) returning the next count;
  - localparam constants for the direction encoding (DIR_UP=1, DIR_DN=0).
- Sub-module jk_bit: single JK flip-flop, rising clk, async active-low rst.
  - Reset q=0.
  - JK encoding: 00 hold, 01 clear, 10 set, 11 toggle.
  - Instantiated WIDTH times via generate.

Test Plan:
- Reset: rst=0 asserted mid-cycle with q=7 -> q=0 and wrap=0 before the next edge; hold rst=0 across 3 edges -> q stays 0.
- Up count: WIDTH=4, MODULUS=10, en=1, up=1 for 12 edges from 0 -> q goes 1..9, 0, 1, 2; tc high only while q=9; wrap high only the cycle after 9->0.
- Down count: from q=1, en=1, up=0 for 3 edges -> q=0, 9, 8; tc high while q=0; wrap pulses after 0->9.
- Load: d=6 with load=1, en=1, up=1 -> q=6, wrap=0. Then d=12 (>= MODULUS) with load=1 -> q=0. Then load=1 with q=9, up=1, en=1 -> load wins, tc=0, no wrap pulse.
- Hold/direction: en=0 for 4 edges at q=5 -> q stays 5, tc=0. Then toggle up every edge with en=1 -> q=6, 5, 6, 5.
- Full range, WIDTH=3, MODULUS=8: count up 9 edges -> 15->0 style wrap at 7->0, wrap pulses once. With JK_CNT_GRAY_OUT_EN defined -> q_gray sequence 000, 001, 011, 010, 110, 111, 101, 100, 000.
